mem_bus_decoder: RTL and testbench



---
 rtl/mem_bus_decoder.sv | 175 +++++++++++++++++
 tb/tb_mem_bus_decoder.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_decoder.sv
// rtl/mem_bus_decoder.sv - CPU bus address decoder with in-order multi-outstanding read routing; MEM_BUS_DECODER_ERR_EN enables error capture
module mem_bus_decoder #(
    parameter int NR_SLAVES       = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter logic [NR_SLAVES*32-1:0] SLAVE_BASE = {NR_SLAVES{32'h0}},
    parameter logic [NR_SLAVES*32-1:0] SLAVE_MASK = {NR_SLAVES{32'h0}}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_cmd_valid,
    output logic                    mem_cmd_ready,
    input  logic                    mem_cmd_wr,
    input  logic                    mem_cmd_instr,
    input  logic [31:0]             mem_cmd_addr,
    input  logic [31:0]             mem_cmd_wdata,
    input  logic [3:0]              mem_cmd_be,
    output logic                    mem_rsp_ready,
    output logic [31:0]             mem_rsp_rdata,
    output logic [NR_SLAVES-1:0]    s_cmd_valid,
    input  logic [NR_SLAVES-1:0]    s_cmd_ready,
    output logic                    s_cmd_wr,
    output logic                    s_cmd_instr,
    output logic [31:0]             s_cmd_addr,
    output logic [31:0]             s_cmd_wdata,
    output logic [3:0]              s_cmd_be,
    input  logic [NR_SLAVES-1:0]    s_rsp_ready,
    input  logic [NR_SLAVES*32-1:0] s_rsp_rdata,
    output logic                    err_valid,
    output logic [31:0]             err_addr
);

    localparam int IDXW = $clog2(NR_SLAVES + 1);
    localparam int PTRW = $clog2(MAX_OUTSTANDING);
    localparam int CNTW = PTRW + 1;
    localparam logic [IDXW-1:0] VOID_IDX = IDXW'(NR_SLAVES);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(MAX_OUTSTANDING);

    logic [IDXW-1:0] sel;
    logic            sel_void;
    logic            sel_ready;
    logic            block;
    logic            cmd_acc;
    logic            push;
    logic            pop;

    logic [IDXW-1:0] fifo_mem [MAX_OUTSTANDING];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [CNTW-1:0] count;
    logic [CNTW-1:0] remain;

    logic [IDXW-1:0] head;
    logic            head_void;
    logic            head_rsp;
    logic [31:0]     head_rdata;
    logic            void_rsp;
    logic            next_head_void;

    // Address decode: scan from the top so the lowest matching index wins
    always_comb begin
        sel = VOID_IDX;
        for (int i = NR_SLAVES - 1; i >= 0; i--) begin
            if ((mem_cmd_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32])
                sel = IDXW'(i);
        end
    end

    assign sel_void      = (sel == VOID_IDX);
    assign block         = !mem_cmd_wr && (count == FULL_CNT);
    assign mem_cmd_ready = !block && sel_ready;
    assign cmd_acc       = mem_cmd_valid && mem_cmd_ready;
    assign push          = cmd_acc && !mem_cmd_wr;

    // Per-slave command valid and the selected slave's ready (void always accepts)
    always_comb begin
        s_cmd_valid = '0;
        sel_ready   = sel_void;
        for (int i = 0; i < NR_SLAVES; i++) begin
            if (sel == IDXW'(i)) begin
                s_cmd_valid[i] = mem_cmd_valid && !block;
                sel_ready      = s_cmd_ready[i];
            end
        end
    end

    assign s_cmd_wr    = mem_cmd_wr;
    assign s_cmd_instr = mem_cmd_instr;
    assign s_cmd_addr  = mem_cmd_addr;
    assign s_cmd_wdata = mem_cmd_wdata;
    assign s_cmd_be    = mem_cmd_be;

    assign head      = fifo_mem[rd_ptr];
    assign head_void = (count != '0) && (head == VOID_IDX);

    // Response steering from the slave named by the FIFO head
    always_comb begin
        head_rsp   = 1'b0;
        head_rdata = 32'h0;
        for (int i = 0; i < NR_SLAVES; i++) begin
            if ((count != '0) && (head == IDXW'(i))) begin
                head_rsp   = s_rsp_ready[i];
                head_rdata = s_rsp_rdata[32*i +: 32];
            end
        end
    end

    assign pop           = head_void ? void_rsp : head_rsp;
    assign mem_rsp_ready = pop;
    assign mem_rsp_rdata = head_void ? 32'h0 : head_rdata;

    // Look ahead at the entry that will be at the head next cycle so a void answers on its first cycle there
    always_comb begin
        remain = count - CNTW'(pop);
        if (remain != '0)
            next_head_void = (fifo_mem[rd_ptr + PTRW'(pop)] == VOID_IDX);
        else
            next_head_void = push && sel_void;
    end

    // Read-tracking FIFO pointers, occupancy and the void responder
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            void_rsp <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count    <= count + CNTW'(push) - CNTW'(pop);
            void_rsp <= next_head_void;
        end
    end

    // FIFO storage of the responder index for each outstanding read
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= sel;
    end

`ifdef MEM_BUS_DECODER_ERR_EN
    logic [NR_SLAVES-1:0] head_onehot;
    logic                 void_acc;
    logic                 proto_err;

    // One-hot of the slave allowed to respond right now
    always_comb begin
        head_onehot = '0;
        for (int i = 0; i < NR_SLAVES; i++) begin
            if ((count != '0) && (head == IDXW'(i)))
                head_onehot[i] = 1'b1;
        end
    end

    assign void_acc  = cmd_acc && sel_void;
    assign proto_err = |(s_rsp_ready & ~head_onehot);

    // Sticky error flag; the first error's address is kept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_valid <= 1'b0;
            err_addr  <= 32'h0;
        end else if (!err_valid && (void_acc || proto_err)) begin
            err_valid <= 1'b1;
            err_addr  <= void_acc ? mem_cmd_addr : 32'hFFFF_FFFF;
        end
    end
`else
    assign err_valid = 1'b0;
    assign err_addr  = 32'h0;
`endif

endmodule

// File: tb/tb_mem_bus_decoder.sv
// tb/tb_mem_bus_decoder.sv - self-checking bench for mem_bus_decoder
module tb_mem_bus_decoder;

`ifdef MEM_BUS_DECODER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int MAXO = 4;

    logic        clk;
    logic        reset;
    logic        mem_cmd_valid;
    logic        mem_cmd_ready;
    logic        mem_cmd_wr;
    logic        mem_cmd_instr;
    logic [31:0] mem_cmd_addr;
    logic [31:0] mem_cmd_wdata;
    logic [3:0]  mem_cmd_be;
    logic        mem_rsp_ready;
    logic [31:0] mem_rsp_rdata;
    logic [1:0]  s_cmd_valid;
    logic [1:0]  s_cmd_ready;
    logic        s_cmd_wr;
    logic        s_cmd_instr;
    logic [31:0] s_cmd_addr;
    logic [31:0] s_cmd_wdata;
    logic [3:0]  s_cmd_be;
    logic [1:0]  s_rsp_ready;
    logic [63:0] s_rsp_rdata;
    logic        err_valid;
    logic [31:0] err_addr;

    mem_bus_decoder #(
        .NR_SLAVES(2),
        .MAX_OUTSTANDING(MAXO),
        .SLAVE_BASE({32'hF000_0000, 32'h0000_0000}),
        .SLAVE_MASK({32'hFFFF_F000, 32'hFFFF_E000})
    ) dut (
        .clk(clk), .reset(reset),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_wr(mem_cmd_wr), .mem_cmd_instr(mem_cmd_instr),
        .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wdata(mem_cmd_wdata),
        .mem_cmd_be(mem_cmd_be),
        .mem_rsp_ready(mem_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
        .s_cmd_wr(s_cmd_wr), .s_cmd_instr(s_cmd_instr),
        .s_cmd_addr(s_cmd_addr), .s_cmd_wdata(s_cmd_wdata), .s_cmd_be(s_cmd_be),
        .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata),
        .err_valid(err_valid), .err_addr(err_addr)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  srdy;
        logic [1:0]  exp_sv;
        logic        exp_rdy;
    } vec_t;

    vec_t        vecs [8];
    int          tests;
    int          fails;
    int          q [$];
    logic        err_v;
    logic [31:0] err_a;
    int          s;
    int          h;
    int          r;
    logic        blk;
    logic        e_rdy;
    logic [1:0]  e_sv;
    logic        e_rsp;
    logic [31:0] e_data;
    logic        proto;
    logic        acc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_cmd(input logic [31:0] a);
        mem_cmd_valid = 1'b1;
        mem_cmd_wr    = 1'b0;
        mem_cmd_addr  = a;
    endtask

    function automatic int model_sel(input logic [31:0] a);
        if ((a & 32'hFFFF_E000) == 32'h0000_0000) return 0;
        if ((a & 32'hFFFF_F000) == 32'hF000_0000) return 1;
        return 2;
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        mem_cmd_valid = 1'b0; mem_cmd_wr = 1'b0; mem_cmd_instr = 1'b0;
        mem_cmd_addr = 32'h0; mem_cmd_wdata = 32'h0; mem_cmd_be = 4'h0;
        s_cmd_ready = 2'b00; s_rsp_ready = 2'b00; s_rsp_rdata = 64'h0;

        vecs[0] = '{32'h0000_0010, 1'b0, 2'b11, 2'b01, 1'b1};
        vecs[1] = '{32'h0000_1FFC, 1'b1, 2'b01, 2'b01, 1'b1};
        vecs[2] = '{32'h0000_2000, 1'b0, 2'b00, 2'b00, 1'b1};
        vecs[3] = '{32'hF000_0004, 1'b1, 2'b00, 2'b10, 1'b0};
        vecs[4] = '{32'hF000_0FFF, 1'b0, 2'b10, 2'b10, 1'b1};
        vecs[5] = '{32'hF000_1000, 1'b0, 2'b00, 2'b00, 1'b1};
        vecs[6] = '{32'h8000_0000, 1'b1, 2'b11, 2'b00, 1'b1};
        vecs[7] = '{32'h0000_0000, 1'b0, 2'b10, 2'b01, 1'b0};

        tick();
        tick();
        chk("reset_rsp_ready", mem_rsp_ready, 1'b0);
        chk("reset_s_cmd_valid", s_cmd_valid, 2'b00);
        chk("reset_err_valid", err_valid, 1'b0);
        chk("reset_err_addr", err_addr, 32'h0);
        reset = 1'b0;

        // Combinational decode table; valid is dropped before each edge so nothing is accepted
        for (int i = 0; i < 8; i++) begin
            tick();
            mem_cmd_valid = 1'b1;
            mem_cmd_addr  = vecs[i].addr;
            mem_cmd_wr    = vecs[i].wr;
            s_cmd_ready   = vecs[i].srdy;
            mem_cmd_wdata = 32'hA5A5_0000 + i;
            #1;
            chk($sformatf("tbl%0d_s_cmd_valid", i), s_cmd_valid, vecs[i].exp_sv);
            chk($sformatf("tbl%0d_cmd_ready", i), mem_cmd_ready, vecs[i].exp_rdy);
            chk($sformatf("tbl%0d_s_cmd_addr", i), s_cmd_addr, vecs[i].addr);
            chk($sformatf("tbl%0d_s_cmd_wdata", i), s_cmd_wdata, 32'hA5A5_0000 + i);
            mem_cmd_valid = 1'b0;
        end

        // Mapped read to slave0 with pass-through data
        tick();
        read_cmd(32'h0000_0010);
        s_cmd_ready = 2'b11;
        #1;
        chk("rd0_s_cmd_valid", s_cmd_valid, 2'b01);
        chk("rd0_cmd_ready", mem_cmd_ready, 1'b1);
        chk("rd0_no_rsp_yet", mem_rsp_ready, 1'b0);
        tick();
        mem_cmd_valid = 1'b0;
        s_rsp_ready = 2'b01;
        s_rsp_rdata = {32'hDEAD_BEEF, 32'h1234_5678};
        #1;
        chk("rd0_rsp_ready", mem_rsp_ready, 1'b1);
        chk("rd0_rsp_rdata", mem_rsp_rdata, 32'h1234_5678);
        tick();
        s_rsp_ready = 2'b00;
        #1;
        chk("rd0_rsp_done", mem_rsp_ready, 1'b0);

        // Write stalled by slave1 for three cycles
        for (int k = 0; k < 3; k++) begin
            tick();
            mem_cmd_valid = 1'b1; mem_cmd_wr = 1'b1; mem_cmd_addr = 32'hF000_0004;
            s_cmd_ready = 2'b00;
            #1;
            chk($sformatf("wr_stall%0d_ready", k), mem_cmd_ready, 1'b0);
            chk($sformatf("wr_stall%0d_valid", k), s_cmd_valid, 2'b10);
        end
        tick();
        s_cmd_ready = 2'b10;
        #1;
        chk("wr_accept_ready", mem_cmd_ready, 1'b1);
        tick();
        mem_cmd_valid = 1'b0;
        #1;
        chk("wr_no_rsp", mem_rsp_ready, 1'b0);

        // Fill the FIFO; the fifth read waits, even during the cycle a pop happens
        s_cmd_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            read_cmd(32'h0000_0100 + 4 * k);
            #1;
            chk($sformatf("fill%0d_ready", k), mem_cmd_ready, 1'b1);
        end
        tick();
        read_cmd(32'h0000_0200);
        #1;
        chk("full_ready", mem_cmd_ready, 1'b0);
        chk("full_s_cmd_valid", s_cmd_valid, 2'b00);
        tick();
        s_rsp_ready = 2'b01;
        s_rsp_rdata = {32'h0, 32'h0000_0001};
        #1;
        chk("full_pop_ready_still_blocked", mem_cmd_ready, 1'b0);
        chk("full_pop_rsp", mem_rsp_ready, 1'b1);
        tick();
        s_rsp_ready = 2'b00;
        #1;
        chk("after_pop_ready", mem_cmd_ready, 1'b1);
        tick();
        mem_cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_rsp_ready = 2'b01;
            s_rsp_rdata = {32'h0, 32'h100 + k};
            #1;
            chk($sformatf("drain%0d_rsp", k), mem_rsp_ready, 1'b1);
            chk($sformatf("drain%0d_data", k), mem_rsp_rdata, 32'h100 + k);
            tick();
        end
        s_rsp_ready = 2'b00;
        #1;
        chk("drained_rsp", mem_rsp_ready, 1'b0);

        // Void read answered one cycle after acceptance
        tick();
        read_cmd(32'h8000_0000);
        s_rsp_rdata = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
        #1;
        chk("void_cmd_ready", mem_cmd_ready, 1'b1);
        chk("void_s_cmd_valid", s_cmd_valid, 2'b00);
        chk("void_rsp_not_yet", mem_rsp_ready, 1'b0);
        tick();
        mem_cmd_valid = 1'b0;
        #1;
        chk("void_rsp_ready", mem_rsp_ready, 1'b1);
        chk("void_rsp_rdata", mem_rsp_rdata, 32'h0);
        chk("void_err_valid", err_valid, ERR_EN);
        chk("void_err_addr", err_addr, ERR_EN ? 32'h8000_0000 : 32'h0);
        tick();
        #1;
        chk("void_rsp_one_cycle", mem_rsp_ready, 1'b0);

        // Interleave slave0, void, slave1 with an early slave1 response
        tick();
        read_cmd(32'h0000_0010);
        tick();
        read_cmd(32'h8000_0004);
        tick();
        read_cmd(32'hF000_0000);
        tick();
        mem_cmd_valid = 1'b0;
        s_rsp_ready = 2'b10;
        s_rsp_rdata = {32'hCCCC_0001, 32'hAAAA_0001};
        #1;
        chk("il_early_s1_ignored", mem_rsp_ready, 1'b0);
        tick();
        s_rsp_ready = 2'b01;
        #1;
        chk("il_s0_rsp", mem_rsp_ready, 1'b1);
        chk("il_s0_data", mem_rsp_rdata, 32'hAAAA_0001);
        tick();
        s_rsp_ready = 2'b00;
        #1;
        chk("il_void_rsp", mem_rsp_ready, 1'b1);
        chk("il_void_data", mem_rsp_rdata, 32'h0);
        tick();
        s_rsp_ready = 2'b10;
        #1;
        chk("il_s1_rsp", mem_rsp_ready, 1'b1);
        chk("il_s1_data", mem_rsp_rdata, 32'hCCCC_0001);
        tick();
        s_rsp_ready = 2'b00;
        #1;
        chk("il_done", mem_rsp_ready, 1'b0);
        chk("il_err_valid", err_valid, ERR_EN);
        chk("il_err_addr_kept", err_addr, ERR_EN ? 32'h8000_0000 : 32'h0);

        // Reset with three reads outstanding
        for (int k = 0; k < 3; k++) begin
            tick();
            read_cmd(32'h0000_0040 + 4 * k);
        end
        tick();
        mem_cmd_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_mid_rsp", mem_rsp_ready, 1'b0);
        chk("rst_mid_err", err_valid, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        #1;
        chk("rst_rel_rsp", mem_rsp_ready, 1'b0);
        chk("rst_rel_err", err_valid, 1'b0);
        s_rsp_ready = 2'b01;
        #1;
        chk("stale_rsp_dropped", mem_rsp_ready, 1'b0);
        tick();
        s_rsp_ready = 2'b00;
        #1;
        chk("stale_err_valid", err_valid, ERR_EN);
        chk("stale_err_addr", err_addr, ERR_EN ? 32'hFFFF_FFFF : 32'h0);

        // Randomized traffic against an in-order queue model
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q = {};
        err_v = 1'b0;
        err_a = 32'h0;
        for (int n = 0; n < 600; n++) begin
            tick();
            mem_cmd_valid = ($urandom_range(0, 3) != 0);
            mem_cmd_wr    = ($urandom_range(0, 2) == 0);
            mem_cmd_instr = 1'($urandom);
            mem_cmd_wdata = $urandom;
            mem_cmd_be    = 4'($urandom);
            r = $urandom_range(0, 2);
            if (r == 0)      mem_cmd_addr = {19'h0, 13'($urandom)};
            else if (r == 1) mem_cmd_addr = {20'hF0000, 12'($urandom)};
            else             mem_cmd_addr = 32'h8000_0000 | 32'($urandom_range(0, 255) << 2);
            s_cmd_ready = 2'($urandom) | 2'($urandom);
            s_rsp_ready = 2'($urandom) & 2'($urandom);
            s_rsp_rdata = {$urandom, $urandom};
            #1;
            s   = model_sel(mem_cmd_addr);
            blk = !mem_cmd_wr && (q.size() == MAXO);
            e_rdy = !blk && ((s == 2) ? 1'b1 : s_cmd_ready[s]);
            e_sv  = (mem_cmd_valid && !blk && s != 2) ? 2'(1 << s) : 2'b00;
            e_rsp = 1'b0;
            e_data = 32'h0;
            h = -1;
            if (q.size() > 0) begin
                h = q[0];
                if (h == 2) begin
                    e_rsp = 1'b1;
                    e_data = 32'h0;
                end else begin
                    e_rsp = s_rsp_ready[h];
                    e_data = s_rsp_rdata[32*h +: 32];
                end
            end
            chk("rnd_cmd_ready", mem_cmd_ready, e_rdy);
            chk("rnd_s_cmd_valid", s_cmd_valid, e_sv);
            chk("rnd_rsp_ready", mem_rsp_ready, e_rsp);
            if (e_rsp)
                chk("rnd_rsp_rdata", mem_rsp_rdata, e_data);
            chk("rnd_err_valid", err_valid, err_v);
            chk("rnd_err_addr", err_addr, err_a);
            proto = 1'b0;
            for (int j = 0; j < 2; j++)
                if (s_rsp_ready[j] && j != h) proto = 1'b1;
            acc = mem_cmd_valid && e_rdy;
            if (ERR_EN && !err_v && ((acc && s == 2) || proto)) begin
                err_v = 1'b1;
                err_a = (acc && s == 2) ? mem_cmd_addr : 32'hFFFF_FFFF;
            end
            if (e_rsp) void'(q.pop_front());
            if (acc && !mem_cmd_wr) q.push_back(s);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
